// File: rtl/ahb_lite_decoder_mux_if.sv
// ahb_lite_decoder_mux_if
//   Master-side AHB-Lite signals between the Cortex-M0 and the decoder/mux.
//   modport master : CPU view (drives address/transfer, receives data/ready/response)
//   modport slave  : interconnect view (receives address/transfer, drives data/ready/response)
//   Signals: m_haddr[31:0], m_htrans[1:0], m_hrdata[31:0], m_hready, m_hresp[1:0]
interface ahb_lite_decoder_mux_if;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic [1:0]  m_hresp;

    modport master (
        output m_haddr,
        output m_htrans,
        input  m_hrdata,
        input  m_hready,
        input  m_hresp
    );

    modport slave (
        input  m_haddr,
        input  m_htrans,
        output m_hrdata,
        output m_hready,
        output m_hresp
    );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// ahb_lite_decoder_mux
//   AHB-Lite address decoder and response mux between the Cortex-M0 and the ROM, RAM and
//   peripheral slaves. Unmapped accesses are answered by an internal default slave with the
//   two-cycle ERROR response, and the faulting address is captured.
//   Optional macro BUS_TIMEOUT_EN adds a slave stall watchdog and the timeout_flag output.
// Ports:
//   HCLK, HRESET            : clock, synchronous active-high reset
//   mbus (slave modport)    : master address/transfer in, muxed data/ready/response out
//   s_hready                : HREADY broadcast to all slaves
//   {rom,ram,per}_hsel      : address-phase selects
//   {rom,ram,per}_hrdata, _hready_resp, _hresp : slave data-phase returns
//   err_addr, err_valid     : last unmapped active address, sticky error flag
//   timeout_flag            : sticky stall-timeout flag (BUS_TIMEOUT_EN only)
module ahb_lite_decoder_mux #(
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE       = 32'h2000_0000,
    parameter logic [31:0] PER_BASE       = 32'h4000_0000,
    parameter logic [31:0] REGION_MASK    = 32'hE000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    ahb_lite_decoder_mux_if.slave        mbus,
    output logic                         s_hready,
    output logic                         rom_hsel,
    output logic                         ram_hsel,
    output logic                         per_hsel,
    input  logic [31:0]                  rom_hrdata,
    input  logic [31:0]                  ram_hrdata,
    input  logic [31:0]                  per_hrdata,
    input  logic                         rom_hready_resp,
    input  logic                         ram_hready_resp,
    input  logic                         per_hready_resp,
    input  logic [1:0]                   rom_hresp,
    input  logic [1:0]                   ram_hresp,
    input  logic [1:0]                   per_hresp,
    output logic [31:0]                  err_addr,
    output logic                         err_valid
`ifdef BUS_TIMEOUT_EN
    ,
    output logic                         timeout_flag
`endif
);

    localparam logic [1:0] SEL_ROM = 2'd0;
    localparam logic [1:0] SEL_RAM = 2'd1;
    localparam logic [1:0] SEL_PER = 2'd2;
    localparam logic [1:0] SEL_DEF = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [31:0] addr_masked;
    logic [1:0]  dec_sel;
    logic [1:0]  dsel_q, dsel_d;
    logic [1:0]  st_q, st_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_valid_q, err_valid_d;
    logic        def_hready;
    logic [1:0]  def_hresp;
    logic        slv_hready;
    logic [1:0]  slv_hresp;
    logic [31:0] slv_hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        active;
    logic        def_start;

    // Address decode; earlier regions win on overlap.
    assign addr_masked = mbus.m_haddr & REGION_MASK;

    always_comb begin
        if (addr_masked == ROM_BASE) begin
            dec_sel = SEL_ROM;
        end else if (addr_masked == RAM_BASE) begin
            dec_sel = SEL_RAM;
        end else if (addr_masked == PER_BASE) begin
            dec_sel = SEL_PER;
        end else begin
            dec_sel = SEL_DEF;
        end
    end

    assign rom_hsel = (dec_sel == SEL_ROM);
    assign ram_hsel = (dec_sel == SEL_RAM);
    assign per_hsel = (dec_sel == SEL_PER);

    // Default slave response from FSM state.
    always_comb begin
        def_hready = 1'b1;
        def_hresp  = RESP_OKAY;
        case (st_q)
            ST_ERR1: begin
                def_hready = 1'b0;
                def_hresp  = RESP_ERROR;
            end
            ST_ERR2: begin
                def_hready = 1'b1;
                def_hresp  = RESP_ERROR;
            end
            default: ;
        endcase
    end

    // Data-phase mux keyed by the select registered in the previous address phase.
    always_comb begin
        slv_hrdata = 32'h0;
        slv_hready = def_hready;
        slv_hresp  = def_hresp;
        unique case (dsel_q)
            SEL_ROM: begin
                slv_hrdata = rom_hrdata;
                slv_hready = rom_hready_resp;
                slv_hresp  = rom_hresp;
            end
            SEL_RAM: begin
                slv_hrdata = ram_hrdata;
                slv_hready = ram_hready_resp;
                slv_hresp  = ram_hresp;
            end
            SEL_PER: begin
                slv_hrdata = per_hrdata;
                slv_hready = per_hready_resp;
                slv_hresp  = per_hresp;
            end
            default: ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        to2_q, to2_d;
    logic        to_flag_q, to_flag_d;
    logic        to1;

    // First override cycle fires when the stall count reaches the limit; the registered
    // second cycle completes the ERROR pair and lets dsel reload.
    assign to1 = (dsel_q != SEL_DEF) && (cnt_q == 16'(TIMEOUT_CYCLES - 1)) && !to2_q;

    always_comb begin
        hready    = to1 ? 1'b0 : (to2_q ? 1'b1 : slv_hready);
        hresp     = (to1 || to2_q) ? RESP_ERROR : slv_hresp;
        to2_d     = to1;
        to_flag_d = to_flag_q | to1;
        if (hready) begin
            cnt_d = 16'h0;
        end else if (dsel_q != SEL_DEF) begin
            cnt_d = cnt_q + 16'h1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q     <= 16'h0;
            to2_q     <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            to2_q     <= to2_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign timeout_flag = to_flag_q;
`else
    assign hready = slv_hready;
    assign hresp  = slv_hresp;
`endif

    assign active    = mbus.m_htrans[1] & hready;
    assign def_start = active && (dec_sel == SEL_DEF);

    always_comb begin
        dsel_d      = hready ? dec_sel : dsel_q;
        err_addr_d  = err_addr_q;
        err_valid_d = err_valid_q;
        if (def_start) begin
            err_addr_d  = mbus.m_haddr;
            err_valid_d = 1'b1;
        end
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (def_start) st_d = ST_ERR1;
            ST_ERR1: st_d = ST_ERR2;
            ST_ERR2: st_d = def_start ? ST_ERR1 : ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q      <= SEL_DEF;
            st_q        <= ST_IDLE;
            err_addr_q  <= 32'h0;
            err_valid_q <= 1'b0;
        end else begin
            dsel_q      <= dsel_d;
            st_q        <= st_d;
            err_addr_q  <= err_addr_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign mbus.m_hrdata = slv_hrdata;
    assign mbus.m_hready = hready;
    assign mbus.m_hresp  = hresp;
    assign s_hready      = hready;
    assign err_addr      = err_addr_q;
    assign err_valid     = err_valid_q;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// tb_ahb_lite_decoder_mux
//   Scoreboard bench: the driver issues transfers and pushes the expected data-phase
//   response; a negedge monitor pops and compares on every completed data phase.
module tb_ahb_lite_decoder_mux;

    localparam int TO_CYC = 16;

    typedef struct {
        int          stalls;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          chk_data;
    } exp_t;

    logic HCLK;
    logic HRESET;
    logic s_hready, rom_hsel, ram_hsel, per_hsel;
    logic [31:0] rom_hrdata, ram_hrdata, per_hrdata;
    logic rom_hready_resp, ram_hready_resp, per_hready_resp;
    logic [1:0] rom_hresp, ram_hresp, per_hresp;
    logic [31:0] err_addr;
    logic err_valid;
`ifdef BUS_TIMEOUT_EN
    logic timeout_flag;
`endif

    ahb_lite_decoder_mux_if bus ();

    ahb_lite_decoder_mux dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .mbus            (bus),
        .s_hready        (s_hready),
        .rom_hsel        (rom_hsel),
        .ram_hsel        (ram_hsel),
        .per_hsel        (per_hsel),
        .rom_hrdata      (rom_hrdata),
        .ram_hrdata      (ram_hrdata),
        .per_hrdata      (per_hrdata),
        .rom_hready_resp (rom_hready_resp),
        .ram_hready_resp (ram_hready_resp),
        .per_hready_resp (per_hready_resp),
        .rom_hresp       (rom_hresp),
        .ram_hresp       (ram_hresp),
        .per_hresp       (per_hresp),
        .err_addr        (err_addr),
        .err_valid       (err_valid)
`ifdef BUS_TIMEOUT_EN
        ,
        .timeout_flag    (timeout_flag)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int stalls = 0;
    exp_t exp_q[$];

    // Slave models: data, response and the cycle from which they report ready.
    logic [31:0] sd [3];
    logic [1:0]  sr [3];
    int          rdy [3];
    logic [31:0] m_err_addr;
    logic        m_err_valid;

    assign rom_hrdata      = sd[0];
    assign ram_hrdata      = sd[1];
    assign per_hrdata      = sd[2];
    assign rom_hresp       = sr[0];
    assign ram_hresp       = sr[1];
    assign per_hresp       = sr[2];
    assign rom_hready_resp = (cyc >= rdy[0]);
    assign ram_hready_resp = (cyc >= rdy[1]);
    assign per_hready_resp = (cyc >= rdy[2]);

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 0 ROM, 1 RAM, 2 PER, 3 unmapped; regions are 512 MB windows at the bottom of the map.
    function automatic int region(input logic [31:0] a);
        if (a < 32'h2000_0000) return 0;
        if (a < 32'h4000_0000) return 1;
        if (a < 32'h6000_0000) return 2;
        return 3;
    endfunction

    // Monitor: every cycle with ready high closes exactly one data phase.
    always @(negedge HCLK) begin
        exp_t e;
        if (HRESET || !mon_en) begin
            stalls = 0;
        end else begin
            chk("s_hready_eq", {31'h0, s_hready}, {31'h0, bus.m_hready});
            if (bus.m_hready !== 1'b1) begin
                stalls++;
                if (stalls == 400) chk("stall_bound", 32'(stalls), 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("stalls", 32'(stalls), 32'(e.stalls));
                chk("hresp", {30'h0, bus.m_hresp}, {30'h0, e.resp});
                if (e.chk_data) chk("hrdata", bus.m_hrdata, e.data);
                stalls = 0;
            end
        end
    end

    task automatic push(input int s, input logic [31:0] d, input logic [1:0] r, input bit cd);
        exp_t e;
        e.stalls = s;
        e.data = d;
        e.resp = r;
        e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    task automatic finish_run(input bit fatal);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (fatal) $fatal(1, "aborted");
        $finish;
    endtask

    // Present one address phase, wait for acceptance, then set up the target slave.
    task automatic issue(input logic [31:0] a, input logic [1:0] tr, input int w,
                         input logic [31:0] d, input logic [1:0] r);
        int rg;
        int n;
        bit act;
        logic [2:0] exp_sel;
        rg = region(a);
        bus.m_haddr = a;
        bus.m_htrans = tr;
        #1;
        exp_sel = (rg < 3) ? (3'b100 >> rg) : 3'b000;
        chk("hsel", {29'h0, rom_hsel, ram_hsel, per_hsel}, {29'h0, exp_sel});
        n = 0;
        forever begin
            @(negedge HCLK);
            if (bus.m_hready === 1'b1) break;
            n++;
            if (n > 300) begin
                errors++;
                $display("FAIL accept_timeout: got no ready after %0d cycles expected ready", n);
                finish_run(1'b1);
            end
        end
        @(posedge HCLK);
        #1;
        act = tr[1];
        if (rg < 3) begin
            rdy[rg] = cyc + (act ? w : 0);
            sd[rg] = d;
            sr[rg] = act ? r : 2'b00;
        end
        if (rg == 3) begin
            if (act) begin
                push(1, 32'h0, 2'b01, 1'b1);
                m_err_addr = a;
                m_err_valid = 1'b1;
                chk("err_valid", {31'h0, err_valid}, {31'h0, m_err_valid});
                chk("err_addr", err_addr, m_err_addr);
            end else begin
                push(0, 32'h0, 2'b00, 1'b1);
            end
        end else if (!act) begin
            push(0, d, 2'b00, 1'b1);
`ifdef BUS_TIMEOUT_EN
        end else if (w >= TO_CYC) begin
            push(TO_CYC, 32'h0, 2'b01, 1'b0);
`endif
        end else begin
            push(w, d, r, 1'b1);
        end
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        bus.m_htrans = 2'b00;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) rdy[i] = 0;
        m_err_addr = 32'h0;
        m_err_valid = 1'b0;
        push(0, 32'h0, 2'b00, 1'b1);
        chk("rst_err_valid", {31'h0, err_valid}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_hready", {31'h0, bus.m_hready}, 32'h1);
        chk("rst_hresp", {30'h0, bus.m_hresp}, 32'h0);
        chk("rst_hrdata", bus.m_hrdata, 32'h0);
`ifdef BUS_TIMEOUT_EN
        chk("rst_timeout_flag", {31'h0, timeout_flag}, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] top;
        for (int i = 0; i < 3; i++) begin
            sd[i] = 32'h0;
            sr[i] = 2'b00;
            rdy[i] = 0;
        end
        HRESET = 1'b1;
        bus.m_haddr = 32'h0;
        bus.m_htrans = 2'b00;
        repeat (3) @(posedge HCLK);
        mon_en = 1'b1;
        do_reset();

        // Idle bus across all regions.
        issue(32'h0000_0040, 2'b00, 0, 32'h1111_1111, 2'b00);
        issue(32'h2000_0040, 2'b01, 0, 32'h2222_2222, 2'b00);
        issue(32'hC000_0000, 2'b00, 0, 32'h0, 2'b00);
        // RAM read with one wait state.
        issue(32'h2000_0010, 2'b10, 1, 32'hDEAD_BEEF, 2'b00);
        // Unmapped access.
        issue(32'h6000_0004, 2'b10, 0, 32'h0, 2'b00);
        // Back-to-back unmapped; second accepted in ERR2.
        issue(32'h8000_0000, 2'b10, 0, 32'h0, 2'b00);
        issue(32'hA000_0000, 2'b10, 0, 32'h0, 2'b00);
        // Alternating ROM/PER reads.
        for (int i = 0; i < 4; i++) begin
            issue(32'h0000_0100, 2'b10, 0, 32'hA0A0_0000 + 32'(i), 2'b00);
            issue(32'h4000_0000, 2'b11, 0, 32'h5050_0000 + 32'(i), 2'b00);
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            top = $urandom_range(0, 7);
            a = {top[2:0], 29'($urandom)};
            issue(a, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00);
        end

        // Reset in the middle of a RAM wait state.
        issue(32'h2000_0000, 2'b10, 8, 32'h1234_5678, 2'b00);
        repeat (2) begin
            @(posedge HCLK);
            #1;
        end
        do_reset();
        issue(32'h0000_0000, 2'b10, 0, 32'hCAFE_F00D, 2'b00);

`ifdef BUS_TIMEOUT_EN
        // Peripheral stalls indefinitely; watchdog terminates with an ERROR pair.
        issue(32'h4000_0008, 2'b10, 100000, 32'h0, 2'b00);
        issue(32'h2000_0004, 2'b10, 0, 32'h7777_7777, 2'b00);
        chk("timeout_flag", {31'h0, timeout_flag}, 32'h1);
        issue(32'h4000_000C, 2'b10, 200, 32'h0, 2'b00);
        repeat (4) begin
            @(posedge HCLK);
            #1;
        end
        do_reset();
`endif

        issue(32'hE000_0000, 2'b00, 0, 32'h0, 2'b00);
        @(negedge HCLK);
        #1;
        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        finish_run(1'b0);
    end

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
- AHB-Lite interconnect stage between the Cortex-M0 master port and the bus slaves (ROM, RAM, peripheral).
- In the address phase it decodes HADDR into one-hot slave selects and broadcasts HREADY to all slaves.
- In the data phase it muxes HRDATA/HREADY/HRESP back from the slave selected in the previous address phase.
- Contains a default slave that answers unmapped accesses with the two-cycle ERROR response, and captures the faulting address.

Parameters:
- ROM_BASE, 32'h0000_0000, ROM region base.
- RAM_BASE, 32'h2000_0000, RAM region base.
- PER_BASE, 32'h4000_0000, peripheral region base.
- REGION_MASK, 32'hE000_0000, mask applied to HADDR before compare, common to all regions.
- TIMEOUT_CYCLES, 16, stall limit used only with BUS_TIMEOUT_EN; legal range 2..65535.

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- m_haddr  in  32  master address.
- m_htrans  in  2  master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- m_hrdata  out  32  muxed read data to master.
- m_hready  out  1  muxed ready to master; also broadcast as slave HREADY.
- m_hresp  out  2  muxed response: 00 OKAY, 01 ERROR.
- s_hready  out  1  HREADY to all slaves; equals m_hready.
- rom_hsel, ram_hsel, per_hsel  out  1 each  address-phase selects.
- rom_hrdata, ram_hrdata, per_hrdata  in  32 each  slave read data.
- rom_hready_resp, ram_hready_resp, per_hready_resp  in  1 each  slave ready.
- rom_hresp, ram_hresp, per_hresp  in  2 each  slave response.
- err_addr  out  32  HADDR of the most recent unmapped active access.
- err_valid  out  1  sticky flag: an unmapped access occurred.

Behaviour:
- Decode is combinational on m_haddr:
  - hit_x = ((m_haddr & REGION_MASK) == X_BASE).
  - Priority on overlap: ROM > RAM > PER.
  - No hit selects the default slave (DEF).
  - hsel outputs follow the decode regardless of htrans; slaves qualify with htrans themselves.
- Active transfer: m_htrans[1]==1 and m_hready==1.
- Data-phase select register dsel (ROM/RAM/PER/DEF):
  - Loads the decode result on every cycle with m_hready==1; holds otherwise.
  - Reset value is DEF.
- Output mux:
  - dsel in ROM/RAM/PER: m_hrdata, m_hready and m_hresp come from that slave.
  - dsel==DEF: m_hrdata=0; m_hready and m_hresp come from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2; reset state IDLE:
  - IDLE: drives hready=1, hresp=OKAY. Moves to ERR1 on an active transfer decoding to DEF; otherwise stays in IDLE.
  - ERR1: drives hready=0, hresp=ERROR. Always moves to ERR2.
  - ERR2: drives hready=1, hresp=ERROR. Moves to ERR1 if a new active transfer decoding to DEF is accepted this cycle; otherwise moves to IDLE.
- IDLE/BUSY transfers to any region, including DEF, get a zero-wait OKAY; no FSM entry.
- Error capture: on each active transfer decoding to DEF, err_addr <= m_haddr and err_valid <= 1.
- err_valid is cleared only by reset.
- Reset values:
  - dsel=DEF, FSM=IDLE, err_addr=0, err_valid=0.
  - Therefore m_hready=1, m_hresp=00, m_hrdata=0 in the first cycle after reset.
- Reset mid-transfer: HRESET overrides everything, including an ERR1 or a slave wait state. The next cycle shows the reset values.
- Back-to-back transfers across slaves (e.g. RAM then ROM): dsel switches only when m_hready==1, so no data-phase mixing occurs.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle that dsel!=DEF and m_hready==0, and clears when m_hready==1.
  - When count==TIMEOUT_CYCLES-1, the block overrides the slave response for two cycles: first m_hready=0/ERROR, then m_hready=1/ERROR.
  - During the override, s_hready follows the override value.
  - Sticky output timeout_flag (1 bit) sets on the override; it clears only on reset.
  - After the override, dsel reloads normally.
- Undefined: no counter, and no timeout_flag port; a slave may stall indefinitely.

Test Plan:
- Reset, then idle bus -> m_hready=1, m_hresp=00, m_hrdata=0, err_valid=0; all hsel follow haddr.
- NONSEQ to 0x2000_0010, RAM returns 0xDEADBEEF with one wait state -> ram_hsel=1 in the address phase; the next cycle shows m_hready=0, then 1 with m_hrdata=0xDEADBEEF, m_hresp=00.
- NONSEQ to 0x6000_0004 -> data phase is m_hready=0/ERROR, then m_hready=1/ERROR; err_addr=0x6000_0004; err_valid=1.
- Back-to-back NONSEQ 0x8000_0000 then 0xA000_0000 (second issued during ERR2) -> two full ERROR pairs with no OKAY gap; err_addr=0xA000_0000.
- Alternate ROM read 0x0000_0100 and PER read 0x4000_0000 on consecutive cycles with differing slave data -> m_hrdata matches the correct slave each data phase.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, PER holds hready_resp=0 -> ERROR pair starts after 15 stalled cycles and timeout_flag=1. Assert HRESET during the stall -> all reset values on the next cycle.
